// File: rtl/dds_pkg.sv
// Shared DDS/DAC definitions: frame width, default DAC command and SPI transmitter states.
// Macro DAC_LDAC_EN adds the LDAC strobe state to the state set.
package dds_pkg;

  localparam int FRAME_BITS = 16;
  localparam logic [3:0] DAC_CMD = 4'b0011;

`ifdef DAC_LDAC_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    LDAC  = 2'd3
  } dac_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } dac_state_e;
`endif

  function automatic logic [FRAME_BITS-1:0] dac_frame(input logic [3:0] cmd, input logic [11:0] smp);
    return {cmd, smp};
  endfunction

endpackage

// File: rtl/sclk_div.sv
// SCLK half-period tick generator: while enabled, pulses tick once every CLK_DIV clk cycles.
module sclk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Half-period counter; held at zero while disabled so each frame starts phase-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!enable) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick = enable && (cnt_r == LAST);

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for a 16-bit {CMD, sample} DAC frame, with optional LDAC strobe.
// Macro DAC_LDAC_EN: defined adds the LDAC state; undefined ties dac_ldac_n low.
module dac_spi_tx
  import dds_pkg::*;
#(
  parameter int         M       = 12,
  parameter logic [3:0] CMD     = DAC_CMD,
  parameter int         CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] sample,
  input  logic         sample_valid,
  output logic         sample_ready,
  output logic         dac_cs_n,
  output logic         dac_sclk,
  output logic         dac_mosi,
  output logic         dac_ldac_n,
  output logic         frame_done
);

  dac_state_e state_r, state_s;
  logic [4:0] hp_cnt_r, hp_cnt_s;
  logic [FRAME_BITS-1:0] shreg_r, shreg_s;
  logic cs_n_r, cs_n_s;
  logic sclk_r, sclk_s;
  logic mosi_r, mosi_s;
  logic done_r, done_s;
  logic ready_r, ready_s;
  logic tick_s;
  logic [FRAME_BITS-1:0] frame_s;
`ifdef DAC_LDAC_EN
  logic ldac_n_r, ldac_n_s;
`endif

  sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state_r != IDLE),
    .tick   (tick_s)
  );

  assign frame_s = dac_frame(CMD, sample);

  // Next-state and next-output logic; every state transition lands on a half-period tick.
  always_comb begin
    state_s  = state_r;
    hp_cnt_s = hp_cnt_r;
    shreg_s  = shreg_r;
    cs_n_s   = cs_n_r;
    sclk_s   = sclk_r;
    mosi_s   = mosi_r;
    done_s   = 1'b0;
    ready_s  = ready_r;
`ifdef DAC_LDAC_EN
    ldac_n_s = ldac_n_r;
`endif
    case (state_r)
      IDLE: begin
        if (sample_valid && ready_r) begin
          state_s  = SHIFT;
          shreg_s  = frame_s;
          hp_cnt_s = 5'd0;
          cs_n_s   = 1'b0;
          sclk_s   = 1'b0;
          mosi_s   = frame_s[FRAME_BITS-1];
          ready_s  = 1'b0;
        end else begin
          ready_s  = 1'b1;
        end
      end
      SHIFT: begin
        if (tick_s) begin
          if (hp_cnt_r == 5'd31) begin
            state_s  = GAP;
            hp_cnt_s = 5'd0;
            cs_n_s   = 1'b1;
            sclk_s   = 1'b0;
            mosi_s   = 1'b0;
          end else begin
            hp_cnt_s = hp_cnt_r + 5'd1;
            sclk_s   = ~sclk_r;
            // Data advances only on the falling SCLK edge.
            if (sclk_r) begin
              shreg_s = shreg_r << 1;
              mosi_s  = shreg_r[FRAME_BITS-2];
            end else begin
              shreg_s = shreg_r;
            end
          end
        end else begin
          hp_cnt_s = hp_cnt_r;
        end
      end
      GAP: begin
        if (tick_s) begin
`ifdef DAC_LDAC_EN
          state_s  = LDAC;
          ldac_n_s = 1'b0;
`else
          state_s  = IDLE;
          done_s   = 1'b1;
          ready_s  = 1'b1;
`endif
        end else begin
          state_s  = GAP;
        end
      end
`ifdef DAC_LDAC_EN
      LDAC: begin
        if (tick_s) begin
          state_s  = IDLE;
          ldac_n_s = 1'b1;
          done_s   = 1'b1;
          ready_s  = 1'b1;
        end else begin
          state_s  = LDAC;
        end
      end
`endif
      default: begin
        state_s  = IDLE;
        hp_cnt_s = 5'd0;
        cs_n_s   = 1'b1;
        sclk_s   = 1'b0;
        mosi_s   = 1'b0;
        ready_s  = 1'b1;
`ifdef DAC_LDAC_EN
        ldac_n_s = 1'b1;
`endif
      end
    endcase
  end

  // State and output registers; reset drops the bus to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      hp_cnt_r <= 5'd0;
      shreg_r  <= '0;
      cs_n_r   <= 1'b1;
      sclk_r   <= 1'b0;
      mosi_r   <= 1'b0;
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
`ifdef DAC_LDAC_EN
      ldac_n_r <= 1'b1;
`endif
    end else begin
      state_r  <= state_s;
      hp_cnt_r <= hp_cnt_s;
      shreg_r  <= shreg_s;
      cs_n_r   <= cs_n_s;
      sclk_r   <= sclk_s;
      mosi_r   <= mosi_s;
      done_r   <= done_s;
      ready_r  <= ready_s;
`ifdef DAC_LDAC_EN
      ldac_n_r <= ldac_n_s;
`endif
    end
  end

  assign sample_ready = ready_r;
  assign dac_cs_n     = cs_n_r;
  assign dac_sclk     = sclk_r;
  assign dac_mosi     = mosi_r;
  assign frame_done   = done_r;
`ifdef DAC_LDAC_EN
  assign dac_ldac_n   = ldac_n_r;
`else
  assign dac_ldac_n   = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: CLK_DIV=2 and CLK_DIV=1 instances against a cycle-offset model.
module tb_dac_spi_tx;

  localparam logic [3:0] CMD = 4'b0011;
`ifdef DAC_LDAC_EN
  localparam bit LDAC_EN = 1'b1;
`else
  localparam bit LDAC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] smp0 = 12'h000, smp1 = 12'h000;
  logic vld0 = 1'b0, vld1 = 1'b0;
  logic rdy0, cs0, sclk0, mosi0, ldac0, done0;
  logic rdy1, cs1, sclk1, mosi1, ldac1, done1;
  int check_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  dac_spi_tx #(.M(12), .CMD(CMD), .CLK_DIV(2)) u_div2 (
    .clk(clk), .rst_n(rst_n), .sample(smp0), .sample_valid(vld0), .sample_ready(rdy0),
    .dac_cs_n(cs0), .dac_sclk(sclk0), .dac_mosi(mosi0), .dac_ldac_n(ldac0), .frame_done(done0)
  );

  dac_spi_tx #(.M(12), .CMD(CMD), .CLK_DIV(1)) u_div1 (
    .clk(clk), .rst_n(rst_n), .sample(smp1), .sample_valid(vld1), .sample_ready(rdy1),
    .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_mosi(mosi1), .dac_ldac_n(ldac1), .frame_done(done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {cs_n, sclk, mosi, ldac_n, frame_done, sample_ready}
  function automatic logic [5:0] obs(input int d);
    if (d == 0) return {cs0, sclk0, mosi0, ldac0, done0, rdy0};
    else        return {cs1, sclk1, mosi1, ldac1, done1, rdy1};
  endfunction

  function automatic int div_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Cycles from handshake edge to the last non-idle cycle.
  function automatic int frame_len(input int dv);
    return 33 * dv + (LDAC_EN ? dv : 0);
  endfunction

  function automatic logic [5:0] idle_vec();
    return {1'b1, 1'b0, 1'b0, LDAC_EN, 1'b0, 1'b1};
  endfunction

  // Expected outputs t cycles after the handshake edge.
  function automatic logic [5:0] exp_vec(input int dv, input logic [15:0] frame, input int t);
    int h;
    logic sc, mo;
    if (t <= 32 * dv) begin
      h  = (t - 1) / dv;
      sc = (h % 2) == 1;
      mo = frame[15 - h / 2];
      return {1'b0, sc, mo, LDAC_EN, 1'b0, 1'b0};
    end else if (t <= 33 * dv) begin
      return {1'b1, 1'b0, 1'b0, LDAC_EN, 1'b0, 1'b0};
    end else if (t <= frame_len(dv)) begin
      return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      return {1'b1, 1'b0, 1'b0, LDAC_EN, 1'b1, 1'b1};
    end
  endfunction

  task automatic set_sample(input int d, input logic [11:0] v);
    if (d == 0) smp0 = v;
    else smp1 = v;
  endtask

  task automatic set_valid(input int d, input logic v);
    if (d == 0) vld0 = v;
    else vld1 = v;
  endtask

  task automatic check_idle(input int d, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq($sformatf("%s_idle%0d_d%0d", name, i, d), {26'd0, obs(d)}, {26'd0, idle_vec()});
    end
  endtask

  // Entered just after a negedge with the DUT idle; returns at the frame_done negedge.
  task automatic run_frame(input int d, input logic [11:0] val, input bit hold,
                           input bit toggle, input string name);
    int dv, len, rises, done_t;
    logic [15:0] frame, shifted;
    logic [5:0] o;
    logic prev_sclk;
    dv = div_of(d);
    len = frame_len(dv);
    frame = {CMD, val};
    o = obs(d);
    check_eq({name, "_ready_pre"}, {31'd0, o[0]}, 32'd1);
    set_sample(d, val);
    set_valid(d, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_valid(d, 1'b0);
    rises = 0;
    done_t = 0;
    shifted = 16'h0000;
    prev_sclk = 1'b0;
    for (int t = 1; t <= len + 1; t++) begin
      @(negedge clk);
      if (toggle) set_sample(d, 12'($urandom));
      o = obs(d);
      check_eq($sformatf("%s_t%0d", name, t), {26'd0, o}, {26'd0, exp_vec(dv, frame, t)});
      if (o[4] && !prev_sclk) begin
        rises++;
        shifted = {shifted[14:0], o[3]};
      end
      prev_sclk = o[4];
      if (o[1] && done_t == 0) done_t = t;
    end
    check_eq({name, "_sclk_rises"}, 32'(rises), 32'd16);
    check_eq({name, "_data"}, {16'd0, shifted}, {16'd0, frame});
    check_eq({name, "_done_latency"}, 32'(done_t), 32'(len + 1));
  endtask

  initial begin
    logic [11:0] v;
    int d;
    repeat (2) @(negedge clk);
    check_eq("reset_d0", {26'd0, obs(0)}, {26'd0, idle_vec()});
    check_eq("reset_d1", {26'd0, obs(1)}, {26'd0, idle_vec()});
    rst_n = 1'b1;
    check_idle(0, 2, "post_por");
    check_idle(1, 1, "post_por");

    run_frame(0, 12'hA5C, 1'b0, 1'b0, "single");
    check_idle(0, 3, "after_single");

    run_frame(0, 12'h000, 1'b1, 1'b0, "b2b_a");
    run_frame(0, 12'hFFF, 1'b0, 1'b0, "b2b_b");
    check_idle(0, 2, "after_b2b");

    run_frame(0, 12'($urandom), 1'b0, 1'b1, "toggle");
    check_idle(0, 1, "after_toggle");

    run_frame(1, 12'h800, 1'b0, 1'b0, "div1");
    check_idle(1, 2, "after_div1");

    for (int i = 0; i < 6; i++) begin
      d = int'($urandom_range(0, 1));
      v = 12'($urandom);
      run_frame(d, v, 1'b0, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      check_idle(d, int'($urandom_range(1, 3)), $sformatf("rnd%0d", i));
    end

    // Abort mid-frame while bit 7 is on the wire with SCLK high.
    set_sample(0, 12'($urandom));
    set_valid(0, 1'b1);
    @(posedge clk);
    #1 set_valid(0, 1'b0);
    repeat (31) @(negedge clk);
    check_eq("rst_pre_sclk", {31'd0, sclk0}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async", {26'd0, obs(0)}, {26'd0, idle_vec()});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("rst_hold%0d", i), {26'd0, obs(0)}, {26'd0, idle_vec()});
    end
    rst_n = 1'b1;
    check_idle(0, 3, "post_rst");
    run_frame(0, 12'($urandom), 1'b0, 1'b0, "resume");
    check_idle(0, 1, "end");

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", check_cnt);
    $fatal(1, "timeout");
  end

endmodule
